// File: rtl/pcileech_tlp_tx_arb.sv
// pcileech_tlp_tx_arb: packet-atomic 3-source TLP arbiter in front of the PCIe core TX stream,
// gated on tx_buf_av, with a 2-entry output skid buffer and packet/drop statistics.
module pcileech_tlp_tx_arb #(
  parameter int BUF_AV_MIN = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk_pcie,
  input  logic        rst_n,
  input  logic [63:0] s0_tdata,
  input  logic [7:0]  s0_tkeep,
  input  logic        s0_tlast,
  input  logic        s0_tvalid,
  output logic        s0_tready,
  input  logic [63:0] s1_tdata,
  input  logic [7:0]  s1_tkeep,
  input  logic        s1_tlast,
  input  logic        s1_tvalid,
  output logic        s1_tready,
  input  logic [63:0] s2_tdata,
  input  logic [7:0]  s2_tkeep,
  input  logic        s2_tlast,
  input  logic        s2_tvalid,
  output logic        s2_tready,
  output logic [63:0] tx_tdata,
  output logic [7:0]  tx_tkeep,
  output logic        tx_tlast,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  input  logic [5:0]  tx_buf_av,
  input  logic        tx_err_drop,
  output logic [31:0] pkt_cnt,
  output logic [15:0] drop_cnt,
  output logic [1:0]  grant_src
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  typedef struct packed {
    logic        v;
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } beat_t;
  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [SW-1:0] starve_q, starve_d;
  beat_t         hd_q, hd_d, sk_q, sk_d, in_b;
  logic [31:0]   pkt_q, pkt_d;
  logic [15:0]   drop_q, drop_d;
  logic          rdy, in_v, push, pop, arb;
  // A source is only readied while the skid entry is free, so a push never meets a full buffer
  assign rdy       = state_q == BUSY && !sk_q.v;
  assign s0_tready = rdy && grant_q == 2'd0;
  assign s1_tready = rdy && grant_q == 2'd1;
  assign s2_tready = rdy && grant_q == 2'd2;
  assign in_v = grant_q == 2'd0 ? s0_tvalid : grant_q == 2'd1 ? s1_tvalid :
                grant_q == 2'd2 ? s2_tvalid : 1'b0;
  assign in_b = grant_q == 2'd0 ? {1'b1, s0_tlast, s0_tkeep, s0_tdata} :
                grant_q == 2'd1 ? {1'b1, s1_tlast, s1_tkeep, s1_tdata} :
                                  {1'b1, s2_tlast, s2_tkeep, s2_tdata};
  assign push = rdy && in_v;
  assign pop  = hd_q.v && tx_tready;
  assign arb  = state_q == IDLE && (s0_tvalid || s1_tvalid || s2_tvalid) &&
                tx_buf_av >= 6'(BUF_AV_MIN);
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    hd_d     = hd_q;
    sk_d     = sk_q;
    starve_d = (state_q == IDLE && !s2_tvalid) ? '0 : starve_q;
    if (arb) begin
      state_d  = BUSY;
      grant_d  = (starve_q == SW'(STARVE_MAX) && s2_tvalid) ? 2'd2 :
                 s0_tvalid ? 2'd0 : s1_tvalid ? 2'd1 : 2'd2;
      starve_d = (grant_d == 2'd2 || !s2_tvalid) ? '0 : starve_q + 1'b1;
    end
    if (push && in_b.last) begin
      state_d = IDLE;
      grant_d = 2'd3;
    end
    if (pop || !hd_q.v) begin
      hd_d   = sk_q.v ? sk_q : push ? in_b : {1'b0, hd_q[72:0]};
      sk_d.v = 1'b0;
    end else if (push) sk_d = in_b;
    pkt_d  = pkt_q + 32'(pop && hd_q.last);
    drop_d = drop_q + 16'(tx_err_drop && drop_q != 16'hFFFF);
  end
  always_ff @(posedge clk_pcie or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= 2'd3;
      starve_q <= '0;
      hd_q     <= '0;
      sk_q     <= '0;
      pkt_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      starve_q <= starve_d;
      hd_q     <= hd_d;
      sk_q     <= sk_d;
      pkt_q    <= pkt_d;
      drop_q   <= drop_d;
    end
  end
  assign tx_tvalid = hd_q.v;
  assign tx_tlast  = hd_q.last;
  assign tx_tkeep  = hd_q.keep;
  assign tx_tdata  = hd_q.data;
  assign pkt_cnt   = pkt_q;
  assign drop_cnt  = drop_q;
  assign grant_src = grant_q;
endmodule

// File: tb/tb_pcileech_tlp_tx_arb.sv
// tb_pcileech_tlp_tx_arb: directed scenario bench for the TX arbiter with per-source beat queues.
module tb_pcileech_tlp_tx_arb;
  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } bt_t;
  logic        clk_pcie, rst_n;
  logic [63:0] s0_tdata, s1_tdata, s2_tdata, tx_tdata;
  logic [7:0]  s0_tkeep, s1_tkeep, s2_tkeep, tx_tkeep;
  logic        s0_tlast, s1_tlast, s2_tlast, tx_tlast;
  logic        s0_tvalid, s1_tvalid, s2_tvalid, tx_tvalid;
  logic        s0_tready, s1_tready, s2_tready, tx_tready;
  logic [5:0]  tx_buf_av;
  logic        tx_err_drop;
  logic [31:0] pkt_cnt;
  logic [15:0] drop_cnt;
  logic [1:0]  grant_src;
  bt_t q0[$], q1[$], q2[$], got[$], exp_q[$];
  logic [2:0]  hold;
  int chk = 0, err = 0, cyc = 0, s_first = -1, tx_first = -1;

  pcileech_tlp_tx_arb dut (
    .clk_pcie(clk_pcie), .rst_n(rst_n),
    .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tlast(s0_tlast), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tlast(s1_tlast), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .s2_tdata(s2_tdata), .s2_tkeep(s2_tkeep), .s2_tlast(s2_tlast), .s2_tvalid(s2_tvalid), .s2_tready(s2_tready),
    .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep), .tx_tlast(tx_tlast), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .tx_buf_av(tx_buf_av), .tx_err_drop(tx_err_drop),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .grant_src(grant_src)
  );

  initial clk_pcie = 1'b0;
  always #5 clk_pcie = ~clk_pcie;

  function automatic bt_t mk(int s, int t, int i, int n);
    mk.d = {8'(s), 8'(t), 16'(i), 32'hC0FFEE00 ^ 32'(i)};
    mk.k = (i == n - 1) ? 8'h0F : 8'hFF;
    mk.l = (i == n - 1);
  endfunction

  task automatic add_pkt(int s, int t, int n);
    for (int i = 0; i < n; i++)
      if (s == 0) q0.push_back(mk(s, t, i, n));
      else if (s == 1) q1.push_back(mk(s, t, i, n));
      else q2.push_back(mk(s, t, i, n));
  endtask

  task automatic add_exp(int s, int t, int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(s, t, i, n));
  endtask

  task automatic drive();
    s0_tvalid = q0.size() != 0 && !hold[0];
    s1_tvalid = q1.size() != 0 && !hold[1];
    s2_tvalid = q2.size() != 0 && !hold[2];
    {s0_tdata, s0_tkeep, s0_tlast} = q0.size() != 0 ? q0[0] : bt_t'(0);
    {s1_tdata, s1_tkeep, s1_tlast} = q1.size() != 0 ? q1[0] : bt_t'(0);
    {s2_tdata, s2_tkeep, s2_tlast} = q2.size() != 0 ? q2[0] : bt_t'(0);
  endtask

  // Handshakes are judged on the settled values at the falling edge, then applied after the rising edge
  task automatic tick();
    logic h0, h1, h2, th;
    @(negedge clk_pcie);
    h0 = s0_tvalid & s0_tready;
    h1 = s1_tvalid & s1_tready;
    h2 = s2_tvalid & s2_tready;
    th = tx_tvalid & tx_tready;
    if ((h0 | h1 | h2) && s_first < 0) s_first = cyc;
    if (th) begin
      got.push_back({tx_tdata, tx_tkeep, tx_tlast});
      if (tx_first < 0) tx_first = cyc;
    end
    @(posedge clk_pcie);
    #1;
    cyc++;
    if (h0) void'(q0.pop_front());
    if (h1) void'(q1.pop_front());
    if (h2) void'(q2.pop_front());
    drive();
  endtask

  task automatic run(int n, int max);
    for (int i = 0; i < max && got.size() < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete(); q1.delete(); q2.delete(); got.delete(); exp_q.delete();
    hold = '0; s_first = -1; tx_first = -1;
    tx_tready = 1'b1; tx_buf_av = 6'd10; tx_err_drop = 1'b0;
    drive();
    repeat (2) @(posedge clk_pcie);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    chk++; if ({tx_tvalid, tx_tlast, tx_tkeep, tx_tdata} !== 74'd0) begin err++; $display("FAIL reset_tx: got %h expected 0", {tx_tvalid, tx_tlast, tx_tkeep, tx_tdata}); end
    chk++; if ({s0_tready, s1_tready, s2_tready} !== 3'b000) begin err++; $display("FAIL reset_tready: got %b expected 000", {s0_tready, s1_tready, s2_tready}); end
    chk++; if (pkt_cnt !== 32'd0 || drop_cnt !== 16'd0) begin err++; $display("FAIL reset_cnt: got %h/%h expected 0/0", pkt_cnt, drop_cnt); end
    chk++; if (grant_src !== 2'd3) begin err++; $display("FAIL reset_grant: got %0d expected 3", grant_src); end
  endtask

  task automatic test_single();
    do_reset();
    add_pkt(2, 1, 3); add_exp(2, 1, 3); drive();
    tick();
    chk++; if (grant_src !== 2'd2) begin err++; $display("FAIL t1_grant: got %0d expected 2", grant_src); end
    run(3, 30);
    chk++; if (got.size() != exp_q.size()) begin err++; $display("FAIL t1_len: got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      chk++; if (got[i] !== exp_q[i]) begin err++; $display("FAIL t1_beat%0d: got %h expected %h", i, got[i], exp_q[i]); end
    end
    chk++; if (tx_first - s_first != 1) begin err++; $display("FAIL t1_latency: got %0d expected 1", tx_first - s_first); end
    chk++; if (pkt_cnt !== 32'd1) begin err++; $display("FAIL t1_pkt: got %0d expected 1", pkt_cnt); end
    chk++; if (grant_src !== 2'd3) begin err++; $display("FAIL t1_grant_end: got %0d expected 3", grant_src); end
  endtask

  task automatic test_priority();
    do_reset();
    add_pkt(2, 3, 2); add_pkt(1, 2, 2); add_pkt(0, 1, 2);
    add_exp(0, 1, 2); add_exp(1, 2, 2); add_exp(2, 3, 2);
    drive();
    run(6, 60);
    chk++; if (got.size() != exp_q.size()) begin err++; $display("FAIL t2_len: got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      chk++; if (got[i] !== exp_q[i]) begin err++; $display("FAIL t2_beat%0d: got %h expected %h", i, got[i], exp_q[i]); end
    end
    chk++; if (pkt_cnt !== 32'd3) begin err++; $display("FAIL t2_pkt: got %0d expected 3", pkt_cnt); end
  endtask

  task automatic test_starve();
    do_reset();
    add_pkt(2, 32, 2);
    for (int p = 0; p < 10; p++) add_pkt(0, p, 2);
    for (int p = 0; p < 8; p++) add_exp(0, p, 2);
    add_exp(2, 32, 2); add_exp(0, 8, 2); add_exp(0, 9, 2);
    drive();
    run(22, 200);
    chk++; if (got.size() != exp_q.size()) begin err++; $display("FAIL t3_len: got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      chk++; if (got[i] !== exp_q[i]) begin err++; $display("FAIL t3_beat%0d: got %h expected %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    bt_t pb;
    logic pstall, saw_full;
    do_reset();
    add_pkt(1, 4, 4); add_exp(1, 4, 4); drive();
    pstall = 1'b0; saw_full = 1'b0; pb = '0;
    for (int i = 0; i < 40 && got.size() < 4; i++) begin
      if (pstall) begin
        chk++; if ({tx_tvalid, tx_tdata, tx_tkeep, tx_tlast} !== {1'b1, pb}) begin err++; $display("FAIL t4_stable: got %h expected %h", {tx_tvalid, tx_tdata, tx_tkeep, tx_tlast}, {1'b1, pb}); end
      end
      tx_tready = i[0];
      pstall = tx_tvalid && !tx_tready;
      pb = {tx_tdata, tx_tkeep, tx_tlast};
      if (grant_src == 2'd1 && s1_tvalid && !s1_tready) saw_full = 1'b1;
      tick();
    end
    tx_tready = 1'b1;
    chk++; if (saw_full !== 1'b1) begin err++; $display("FAIL t4_full_stall: got %b expected 1", saw_full); end
    chk++; if (got.size() != exp_q.size()) begin err++; $display("FAIL t4_len: got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      chk++; if (got[i] !== exp_q[i]) begin err++; $display("FAIL t4_beat%0d: got %h expected %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_bubble();
    do_reset();
    add_pkt(1, 5, 3); drive();
    tick(); tick();
    hold[1] = 1'b1;
    add_pkt(0, 6, 1); drive();
    tick(); tick();
    chk++; if (grant_src !== 2'd1) begin err++; $display("FAIL tb_grant_held: got %0d expected 1", grant_src); end
    chk++; if (s0_tready !== 1'b0) begin err++; $display("FAIL tb_s0_blocked: got %b expected 0", s0_tready); end
    hold[1] = 1'b0; drive();
    add_exp(1, 5, 3); add_exp(0, 6, 1);
    run(4, 40);
    chk++; if (got.size() != exp_q.size()) begin err++; $display("FAIL tb_len: got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      chk++; if (got[i] !== exp_q[i]) begin err++; $display("FAIL tb_beat%0d: got %h expected %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_buf_av();
    do_reset();
    tx_buf_av = 6'd1;
    add_pkt(1, 7, 2); add_exp(1, 7, 2); drive();
    repeat (3) tick();
    chk++; if (grant_src !== 2'd3 || s1_tready !== 1'b0) begin err++; $display("FAIL t5_no_grant: got %0d/%b expected 3/0", grant_src, s1_tready); end
    tx_buf_av = 6'd2;
    tick();
    chk++; if (grant_src !== 2'd1) begin err++; $display("FAIL t5_grant: got %0d expected 1", grant_src); end
    tx_buf_av = 6'd0;
    run(2, 30);
    chk++; if (got.size() != exp_q.size()) begin err++; $display("FAIL t5_len: got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      chk++; if (got[i] !== exp_q[i]) begin err++; $display("FAIL t5_beat%0d: got %h expected %h", i, got[i], exp_q[i]); end
    end
    chk++; if (pkt_cnt !== 32'd1) begin err++; $display("FAIL t5_pkt: got %0d expected 1", pkt_cnt); end
  endtask

  task automatic test_drop_reset();
    do_reset();
    tx_err_drop = 1'b1;
    repeat (65534) @(posedge clk_pcie);
    #1;
    chk++; if (drop_cnt !== 16'hFFFE) begin err++; $display("FAIL t6_drop_pre: got %h expected fffe", drop_cnt); end
    repeat (7) @(posedge clk_pcie);
    #1 tx_err_drop = 1'b0;
    chk++; if (drop_cnt !== 16'hFFFF) begin err++; $display("FAIL t6_drop_sat: got %h expected ffff", drop_cnt); end
    add_pkt(1, 8, 1); drive();
    run(1, 20);
    chk++; if (pkt_cnt !== 32'd1) begin err++; $display("FAIL t6_pkt_pre: got %0d expected 1", pkt_cnt); end
    tx_tready = 1'b0;
    add_pkt(0, 9, 4); drive();
    repeat (4) tick();
    chk++; if (tx_tvalid !== 1'b1) begin err++; $display("FAIL t6_mid_valid: got %b expected 1", tx_tvalid); end
    #2 rst_n = 1'b0;
    #1;
    chk++; if ({tx_tvalid, tx_tlast, tx_tkeep, tx_tdata} !== 74'd0) begin err++; $display("FAIL t6_rst_tx: got %h expected 0", {tx_tvalid, tx_tlast, tx_tkeep, tx_tdata}); end
    chk++; if ({s0_tready, s1_tready, s2_tready} !== 3'b000 || grant_src !== 2'd3) begin err++; $display("FAIL t6_rst_arb: got %b/%0d expected 000/3", {s0_tready, s1_tready, s2_tready}, grant_src); end
    chk++; if (pkt_cnt !== 32'd0 || drop_cnt !== 16'd0) begin err++; $display("FAIL t6_rst_cnt: got %h/%h expected 0/0", pkt_cnt, drop_cnt); end
    do_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_starve();
    test_backpressure();
    test_bubble();
    test_buf_av();
    test_drop_reset();
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end
endmodule
